// File: rtl/param_dp_ram_ctrl_if.sv
// Bus bundle for param_dp_ram_ctrl: write port, read port and status strobes.
// The master drives the write and read requests. The slave returns the read data and status.
interface param_dp_ram_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              we;
  logic [ADDR_W-1:0] inaddr;
  logic [DATA_W-1:0] din;
  logic              re;
  logic [ADDR_W-1:0] outaddr;
  logic [DATA_W-1:0] dout;
  logic              dout_vld;
  logic              busy;
  logic              wr_drop;

  modport master (
    output we, inaddr, din, re, outaddr,
    input  dout, dout_vld, busy, wr_drop
  );

  modport slave (
    input  we, inaddr, din, re, outaddr,
    output dout, dout_vld, busy, wr_drop
  );
endinterface

// File: rtl/param_dp_ram_ctrl.sv
// Parametrised simple-dual-port RAM with a post-reset clear sequencer,
// a registered read with a valid strobe, selectable read-during-write and write-drop reporting.
module param_dp_ram_ctrl #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 4,
  parameter int                RDW_MODE = 0,
  parameter logic [DATA_W-1:0] INIT_VAL = {DATA_W{1'b0}}
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  param_dp_ram_ctrl_if.slave   bus
);

  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_clr_ptr;
  logic [ADDR_W-1:0] w_clr_ptr_nxt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_dout;
  logic [DATA_W-1:0] w_dout_nxt;
  logic              r_dout_vld;
  logic              w_dout_vld_nxt;
  logic              r_busy;
  logic              w_busy_nxt;
  logic              r_wr_drop;
  logic              w_wr_drop_nxt;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_data;
  logic [DATA_W-1:0] w_rd_data;

  // Next-state, memory write port steering and next output values
  always_comb begin
    w_state_nxt    = r_state;
    w_clr_ptr_nxt  = r_clr_ptr;
    w_busy_nxt     = r_busy;
    w_dout_nxt     = r_dout;
    w_dout_vld_nxt = 1'b0;
    w_wr_drop_nxt  = 1'b0;
    w_mem_we       = 1'b0;
    w_mem_addr     = bus.inaddr;
    w_mem_data     = bus.din;
    // Same-address bypass only when the new-data policy is selected
    if ((RDW_MODE != 0) && bus.we && (bus.inaddr == bus.outaddr)) begin
      w_rd_data = bus.din;
    end else begin
      w_rd_data = r_mem[bus.outaddr];
    end
    case (r_state)
      ST_CLEAR: begin
        w_mem_we      = 1'b1;
        w_mem_addr    = r_clr_ptr;
        w_mem_data    = INIT_VAL;
        w_clr_ptr_nxt = r_clr_ptr + ADDR_W'(1'b1);
        w_wr_drop_nxt = bus.we;
        if (r_clr_ptr == LAST_ADDR) begin
          w_state_nxt = ST_READY;
          w_busy_nxt  = 1'b0;
        end else begin
          w_state_nxt = ST_CLEAR;
          w_busy_nxt  = 1'b1;
        end
      end
      ST_READY: begin
        w_state_nxt    = ST_READY;
        w_busy_nxt     = 1'b0;
        w_mem_we       = bus.we;
        w_dout_vld_nxt = bus.re;
        if (bus.re) begin
          w_dout_nxt = w_rd_data;
        end else begin
          w_dout_nxt = r_dout;
        end
      end
      default: begin
        w_state_nxt   = ST_CLEAR;
        w_clr_ptr_nxt = {ADDR_W{1'b0}};
        w_busy_nxt    = 1'b1;
      end
    endcase
  end

  // State, clear pointer and output registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_CLEAR;
      r_clr_ptr  <= {ADDR_W{1'b0}};
      r_dout     <= {DATA_W{1'b0}};
      r_dout_vld <= 1'b0;
      r_wr_drop  <= 1'b0;
      r_busy     <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_ptr  <= w_clr_ptr_nxt;
      r_dout     <= w_dout_nxt;
      r_dout_vld <= w_dout_vld_nxt;
      r_wr_drop  <= w_wr_drop_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  // Storage array; contents are only ever initialised by the clear sequencer
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_data;
    end
  end

  assign bus.dout     = r_dout;
  assign bus.dout_vld = r_dout_vld;
  assign bus.busy     = r_busy;
  assign bus.wr_drop  = r_wr_drop;

endmodule

// File: tb/tb_param_dp_ram_ctrl.sv
// Self-checking bench: an old-data and a new-data instance share one stimulus stream.
// Both are compared every cycle against an array-based reference model.
module tb_param_dp_ram_ctrl;

  localparam int             DW    = 8;
  localparam int             AW    = 4;
  localparam int             DEPTH = 16;
  localparam logic [DW-1:0]  INIT  = 8'hA5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  param_dp_ram_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) ifc0 ();
  param_dp_ram_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) ifc1 ();

  param_dp_ram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(0), .INIT_VAL(INIT)) dut0 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (ifc0.slave)
  );

  param_dp_ram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(1), .INIT_VAL(INIT)) dut1 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (ifc1.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [DW-1:0] m_mem [DEPTH];
  int            m_clr_left = 0;
  int            m_clr_idx  = 0;
  logic [DW-1:0] m_dout [2];
  logic          m_vld  = 1'b0;
  logic          m_drop = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic we, input logic [AW-1:0] ia,
                     input logic [DW-1:0] d, input logic re, input logic [AW-1:0] oa);
    logic [DW-1:0] old_v;
    rst          = r;
    ifc0.we      = we;  ifc1.we      = we;
    ifc0.inaddr  = ia;  ifc1.inaddr  = ia;
    ifc0.din     = d;   ifc1.din     = d;
    ifc0.re      = re;  ifc1.re      = re;
    ifc0.outaddr = oa;  ifc1.outaddr = oa;
    @(posedge clk);
    if (r) begin
      m_clr_left = DEPTH;
      m_clr_idx  = 0;
      m_dout[0]  = '0;
      m_dout[1]  = '0;
      m_vld      = 1'b0;
      m_drop     = 1'b0;
    end else if (m_clr_left > 0) begin
      m_mem[m_clr_idx] = INIT;
      m_clr_idx        = (m_clr_idx + 1) % DEPTH;
      m_clr_left--;
      m_drop           = we;
      m_vld            = 1'b0;
    end else begin
      old_v  = m_mem[oa];
      m_vld  = re;
      m_drop = 1'b0;
      if (re) begin
        m_dout[0] = old_v;
        m_dout[1] = (we && (ia == oa)) ? d : old_v;
      end
      if (we) m_mem[ia] = d;
    end
    #1;
    chk("dout_old",  32'(ifc0.dout),     32'(m_dout[0]));
    chk("dout_new",  32'(ifc1.dout),     32'(m_dout[1]));
    chk("vld_old",   32'(ifc0.dout_vld), 32'(m_vld));
    chk("vld_new",   32'(ifc1.dout_vld), 32'(m_vld));
    chk("busy_old",  32'(ifc0.busy),     32'(m_clr_left > 0));
    chk("busy_new",  32'(ifc1.busy),     32'(m_clr_left > 0));
    chk("drop_old",  32'(ifc0.wr_drop),  32'(m_drop));
    chk("drop_new",  32'(ifc1.wr_drop),  32'(m_drop));
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
  endtask

  initial begin
    // multi-cycle reset, then clear with a dropped write to addr2 in the middle
    repeat (3) cyc(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 4'd0);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 5) cyc(1'b0, 1'b1, 4'd2, 8'h77, 1'b1, 4'd2);
      else        cyc(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd0);
    end
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'(i));

    // plain writes and reads at the low and top addresses
    cyc(1'b0, 1'b1, 4'd3,  8'h3C, 1'b0, 4'd0);
    cyc(1'b0, 1'b1, 4'd15, 8'hF0, 1'b0, 4'd0);
    cyc(1'b0, 1'b0, 4'd0,  8'h00, 1'b1, 4'd3);
    cyc(1'b0, 1'b0, 4'd0,  8'h00, 1'b1, 4'd15);

    // same-address read during write
    cyc(1'b0, 1'b1, 4'd5, 8'h11, 1'b0, 4'd0);
    cyc(1'b0, 1'b1, 4'd5, 8'h22, 1'b1, 4'd5);
    cyc(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd5);
    cyc(1'b0, 1'b1, 4'd6, 8'h99, 1'b1, 4'd3);

    // re held low: dout holds while outaddr moves
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'(i * 5));

    // reset in the middle of a re-clear
    cyc(1'b0, 1'b1, 4'd7, 8'h5A, 1'b1, 4'd7);
    cyc(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
    repeat (8) idle();
    cyc(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
    repeat (DEPTH) idle();
    cyc(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd7);
    idle();

    // randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      cyc(1'($urandom_range(99, 0) == 0), 1'($urandom), 4'($urandom), 8'($urandom),
          1'($urandom), 4'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
